mul_iter: RTL and testbench

//  Parametrised multi-cycle shift-add multiplier for the MULT/MULTU path of the CPU.

---
 rtl/mul_iter.sv | 128 ++++++++++++
 tb/tb_mul_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, start/done handshake.
// Build option: define MUL_SIGNED_EN to enable signed (MULT) operation via is_signed.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_CALC | consuming one multiplier bit per cycle, WIDTH cycles
  // S_DONE | one-cycle done pulse; start here chains the next product
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic               accept;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum_hi;
  logic [AW-1:0]      acc_step;
  logic [2*WIDTH-1:0] z_fin;

  assign accept = start && (state_q != S_CALC);

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  assign signed_mode = is_signed;
  // Magnitudes stay W-bit unsigned, so the most negative operand maps to 2^(W-1) cleanly.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
  assign z_fin = neg_q ? (2*WIDTH)'(~acc_step[2*WIDTH-1:0] + (2*WIDTH)'(1))
                       : acc_step[2*WIDTH-1:0];

  always_comb begin
    neg_d = neg_q;
    if (accept) neg_d = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end
`else
  // Unsigned-only build: the mode input has no influence on the datapath.
  assign signed_mode = 1'b0 & is_signed;
  assign a_mag       = a;
  assign b_mag       = b;
  assign z_fin       = acc_step[2*WIDTH-1:0];
`endif

  assign addend   = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
  assign sum_hi   = acc_q[AW-1:WIDTH] + {1'b0, addend};
  assign acc_step = {sum_hi, acc_q[WIDTH-1:0]} >> 1;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_CALC;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          z_d     = z_fin;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
    end
  end

  assign busy = (state_q == S_CALC);
  assign done = (state_q == S_DONE);
  assign z    = z_q;

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: timeline/product reference model checked every cycle, plus literal cases.
module tb_mul_iter;
  localparam int W = 32;
`ifdef MUL_SIGNED_EN
  localparam bit SGN_EN = 1'b1;
`else
  localparam bit SGN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [W-1:0]     a = '0, b = '0;
  logic             busy, done;
  logic [2*W-1:0]   z;

  logic             start8 = 1'b0;
  logic [7:0]       a8 = '0, b8 = '0;
  logic             busy8, done8;
  logic [15:0]      z8;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .z(z)
  );

  mul_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(1'b0),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
  );

  // Exact product modulo 2^(2W): sign- or zero-extend, then multiply.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
    logic [2*W-1:0] ex, ey;
    logic sm;
    sm = s & SGN_EN;
    ex = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ey = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return ex * ey;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: an accepted start yields W busy cycles, then one done cycle with the product.
  int             m_left = 0;
  bit             m_done = 1'b0;
  bit             m_fin, m_acc;
  logic [2*W-1:0] m_z = '0, m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_z    = '0;
    end else begin
      m_fin = (m_left == 1);
      m_acc = start && (m_left == 0);
      if (m_left > 0) m_left--;
      m_done = m_fin;
      if (m_fin) m_z = m_pend;
      if (m_acc) begin
        m_left = W;
        m_pend = ref_prod(a, b, is_signed);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", (2*W)'(busy), (2*W)'(m_left > 0));
      check("done", (2*W)'(done), (2*W)'(m_done));
      check("z", z, m_z);
    end
  end

  // Waits for done, clearing start and scrambling operands after acceptance.
  task automatic wait_done(output logic [2*W-1:0] zr, output int lat);
    lat = 0;
    zr  = '0;
    for (int i = 1; i <= W + 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = ~is_signed;
      end
      if (done === 1'b1) begin
        lat = i;
        zr  = z;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        output logic [2*W-1:0] zr, output int lat);
    @(negedge clk);
    start = 1'b1; a = x; b = y; is_signed = s;
    wait_done(zr, lat);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  logic [2*W-1:0] zr;
  int lat, ndone;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", (2*W)'(busy), '0);
    check("rst_done", (2*W)'(done), '0);
    check("rst_z", z, '0);
    reset = 1'b0;

    run_op(3, 5, 1'b0, zr, lat);
    check("t1_z", zr, 64'h0000_0000_0000_000F);
    check("t1_latency", lat, W + 1);

    run_op('1, '1, 1'b0, zr, lat);
    check("t2_unsigned", zr, 64'hFFFF_FFFE_0000_0001);
    run_op('1, '1, 1'b1, zr, lat);
`ifdef MUL_SIGNED_EN
    check("t2_signed", zr, 64'h0000_0000_0000_0001);
`else
    check("t6_ignored_signed", zr, 64'hFFFF_FFFE_0000_0001);
`endif

    run_op(32'hFFFF_FFFD, 32'd7, 1'b1, zr, lat);
`ifdef MUL_SIGNED_EN
    check("t3_neg3x7", zr, 64'hFFFF_FFFF_FFFF_FFEB);
`else
    check("t3_neg3x7_unsigned", zr, 64'h0000_0006_FFFF_FFEB);
`endif
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, zr, lat);
    check("t3_minxmin", zr, 64'h4000_0000_0000_0000);

    // start held through CALC with different operands: only the first op counts
    @(negedge clk);
    start = 1'b1; a = 11; b = 13; is_signed = 1'b0;
    lat = 0;
    for (int i = 1; i <= W + 8; i++) begin
      @(negedge clk);
      if (i <= 20) begin a = $urandom; b = $urandom; end
      else start = 1'b0;
      if (done === 1'b1) begin lat = i; zr = z; break; end
    end
    check("t4_hold_z", zr, 64'd143);
    check("t4_hold_latency", lat, W + 1);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) ndone++; end
    check("t4_single_done", ndone, 0);

    // back-to-back: start raised during the DONE cycle
    run_op(100, 200, 1'b0, zr, lat);
    check("t4_first_z", zr, 64'd20000);
    start = 1'b1; a = 7; b = 9; is_signed = 1'b0;
    wait_done(zr, lat);
    check("t4_b2b_z", zr, 64'd63);
    check("t4_b2b_spacing", lat, W + 1);

    // reset in cycle 10 of CALC aborts the op
    @(negedge clk);
    start = 1'b1; a = 5; b = 6; is_signed = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_busy", (2*W)'(busy), '0);
    check("t5_done", (2*W)'(done), '0);
    check("t5_z", z, '0);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) ndone++; end
    check("t5_no_done", ndone, 0);

    // narrow instance
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h02;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8 === 1'b1) begin lat = i; check("t6_w8_z", 64'(z8), 64'h01FE); break; end
    end
    check("t6_w8_latency", lat, 9);

    // random traffic with occasional reset; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      a         = pick();
      b         = pick();
      is_signed = $urandom_range(0, 1) == 1;
      reset     = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
